// File: rtl/traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// traffic_sensor_conditioner
//
// Front end of the traffic light controller. Turns the raw, bouncing
// car-loop detector lines for road A and road B into clean sensor levels
// SA/SB for the controller.
//
// Each channel has three stages:
//   1. a two-flop synchronizer, because the detector lines are asynchronous
//      to CLK;
//   2. a debounce FSM. It accepts a level change only after DEB_CYCLES
//      consecutive synchronized samples at the new level;
//   3. an optional request latch (LATCH=1). It keeps a detection asserted
//      until the controller shows green on that road, so a car that leaves
//      the loop early is still served.
//
// Parameters
//   DEB_CYCLES  consecutive samples needed to accept a level change (2..255)
//   LATCH       1: hold SA/SB until the road's light is green; 0: plain level
//   GREEN_CODE  encoding of "green" on the controller light outputs A/B
//
// Ports
//   CLK    in   1  system clock, all state on rising edge
//   RST    in   1  asynchronous, active-low reset
//   RAW_A  in   1  raw detector, road A (asynchronous, may bounce)
//   RAW_B  in   1  raw detector, road B (asynchronous, may bounce)
//   A      in   2  controller car light, road A (latch clear)
//   B      in   2  controller car light, road B (latch clear)
//   SA     out  1  conditioned sensor, road A
//   SB     out  1  conditioned sensor, road B
//
// Debounce FSM (one instance per channel)
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no car; waiting for a synchronized high sample
//   ST_QUAL    | high seen; counting consecutive high samples
//   ST_PRESENT | car accepted; sensor asserted
//   ST_RELEASE | low seen while present; counting consecutive low samples
//                (sensor still asserted)
// ---------------------------------------------------------------------------
module traffic_sensor_conditioner #(
    parameter int         DEB_CYCLES = 4,
    parameter bit         LATCH      = 1'b1,
    parameter logic [1:0] GREEN_CODE = 2'b10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RAW_A,
    input  logic       RAW_B,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       SA,
    output logic       SB
);

    // Counter only has to reach DEB_CYCLES-1; keep at least one bit so the
    // legal minimum of DEB_CYCLES=2 still gets a real counter.
    localparam int            CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0] raw_vec;
    logic [1:0] green_vec;
    logic [1:0] sense_vec;

    assign raw_vec   = {RAW_B, RAW_A};
    // Light outputs come from the controller on this same clock, so they
    // are used directly without synchronization.
    assign green_vec = {(B == GREEN_CODE), (A == GREEN_CODE)};

    assign SA = sense_vec[0];
    assign SB = sense_vec[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch

        logic          s1;
        logic          s2;
        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          pend;
        logic          pend_nxt;
        logic          enter_present;
        logic          sense;
        logic          sense_nxt;

        // Two-flop synchronizer. Only s2 is allowed to reach the FSM.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= raw_vec[ch];
                s2 <= s1;
            end
        end

        // Entering QUAL or RELEASE already counts the first sample at the
        // new level. This is why cnt starts at 1 on those transitions.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_IDLE: begin
                    if (s2) begin
                        state_nxt = ST_QUAL;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                ST_QUAL: begin
                    if (!s2) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_PRESENT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                ST_PRESENT: begin
                    if (!s2) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (s2) begin
                        state_nxt = ST_PRESENT;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // A return from RELEASE to PRESENT also counts as entering PRESENT.
        // A car that bounced back onto the loop re-arms its request.
        assign enter_present = (state_nxt == ST_PRESENT) && (state != ST_PRESENT);

        // Green on this road clears the request even on the edge that would
        // set it: the car is being served already.
        always_comb begin
            pend_nxt = 1'b0;
            if (LATCH) begin
                if (green_vec[ch]) begin
                    pend_nxt = 1'b0;
                end else if (enter_present) begin
                    pend_nxt = 1'b1;
                end else begin
                    pend_nxt = pend;
                end
            end
        end

        // The sensor output is built from next-state values, so it changes
        // on the same edge as the FSM. It stays registered, so there is no
        // combinational path from the detector line.
        assign sense_nxt = (state_nxt == ST_PRESENT) ||
                           (state_nxt == ST_RELEASE) ||
                           pend_nxt;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pend  <= 1'b0;
                sense <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                pend  <= pend_nxt;
                sense <= sense_nxt;
            end
        end

        assign sense_vec[ch] = sense;

    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// Testbench for traffic_sensor_conditioner.
// Two instances share all inputs: u_dut_lvl (LATCH=0) and u_dut_lat (LATCH=1).
// A reference model predicts SA/SB for both. It keeps an accepted level
// plus a run length of disagreeing samples.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_conditioner;

    localparam int         DEB   = 4;
    localparam logic [1:0] GREEN = 2'b10;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b0;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic [1:0] lt_a  = 2'b00;
    logic [1:0] lt_b  = 2'b00;
    logic       sa0, sb0, sa1, sb1;

    traffic_sensor_conditioner #(.DEB_CYCLES(DEB), .LATCH(1'b0), .GREEN_CODE(GREEN)) u_dut_lvl (
        .CLK(CLK), .RST(RST), .RAW_A(raw_a), .RAW_B(raw_b),
        .A(lt_a), .B(lt_b), .SA(sa0), .SB(sb0)
    );

    traffic_sensor_conditioner #(.DEB_CYCLES(DEB), .LATCH(1'b1), .GREEN_CODE(GREEN)) u_dut_lat (
        .CLK(CLK), .RST(RST), .RAW_A(raw_a), .RAW_B(raw_b),
        .A(lt_a), .B(lt_b), .SA(sa1), .SB(sb1)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Per-channel reference state. lvl is the accepted level; run counts
    // consecutive synchronized samples that disagree with lvl.
    typedef struct packed {
        logic       s1;
        logic       s2;
        logic       lvl;
        logic       pend;
        logic       sa;
        logic [7:0] run;
    } ch_t;

    typedef struct packed {
        logic sa0;
        logic sb0;
        logic sa1;
        logic sb1;
    } exp_t;

    ch_t  m [4];
    exp_t sb_q [$];
    int   edge_n = 0;

    function automatic ch_t ch_step(input ch_t c, input logic raw, input logic green,
                                    input logic latch);
        ch_t  n;
        logic steady_on;
        logic entered;
        n         = c;
        steady_on = c.lvl && (c.run == 0);
        if (c.s2 != c.lvl) begin
            n.run = c.run + 8'd1;
            if (int'(n.run) == DEB) begin
                n.lvl = c.s2;
                n.run = 8'd0;
            end
        end else begin
            n.run = 8'd0;
        end
        entered = n.lvl && (n.run == 0) && !steady_on;
        if (!latch || green) n.pend = 1'b0;
        else if (entered)    n.pend = 1'b1;
        n.s2 = c.s1;
        n.s1 = raw;
        n.sa = n.lvl | n.pend;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m[i] = '0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict, then check after the edge.
    task automatic step(input logic ra, input logic rb, input logic [1:0] la,
                        input logic [1:0] lb);
        exp_t e;
        @(negedge CLK);
        raw_a = ra;
        raw_b = rb;
        lt_a  = la;
        lt_b  = lb;
        m[0] = ch_step(m[0], ra, la == GREEN, 1'b0);
        m[1] = ch_step(m[1], rb, lb == GREEN, 1'b0);
        m[2] = ch_step(m[2], ra, la == GREEN, 1'b1);
        m[3] = ch_step(m[3], rb, lb == GREEN, 1'b1);
        sb_q.push_back('{m[0].sa, m[1].sa, m[2].sa, m[3].sa});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk($sformatf("sb_e%0d_sa_lvl", edge_n), sa0, e.sa0);
        chk($sformatf("sb_e%0d_sb_lvl", edge_n), sb0, e.sb0);
        chk($sformatf("sb_e%0d_sa_lat", edge_n), sa1, e.sa1);
        chk($sformatf("sb_e%0d_sb_lat", edge_n), sb1, e.sb1);
        edge_n++;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_sa_lvl", sa0, 1'b0);
        chk("reset_sb_lvl", sb0, 1'b0);
        chk("reset_sa_lat", sa1, 1'b0);
        chk("reset_sb_lat", sb1, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        // T2 latency: raw A high for edges 0..19, low from edge 20.
        for (int i = 0; i < 30; i++) begin
            step((i < 20), 1'b0, 2'b00, 2'b00);
            if (i == 4)  chk("t2_e4_sa_low",   sa0, 1'b0);
            if (i == 5)  chk("t2_e5_sa_high",  sa0, 1'b1);
            if (i == 24) chk("t2_e24_sa_high", sa0, 1'b1);
            if (i == 25) chk("t2_e25_sa_low",  sa0, 1'b0);
            if (i == 29) chk("t2_latched_sa",  sa1, 1'b1);
        end
        step(1'b0, 1'b0, GREEN, 2'b00);
        chk("t2_green_clear", sa1, 1'b0);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // T3 glitch: 3-sample high pulse on B never asserts.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i < 3), 2'b00, 2'b00);
            chk("t3_glitch_sb_lvl", sb0, 1'b0);
            chk("t3_glitch_sb_lat", sb1, 1'b0);
        end
        // Car present, then a 3-sample dip: SB holds.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b00, 2'b00);
        chk("t3_present_sb", sb0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b00, 2'b00);
            chk("t3_dip_sb", sb0, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 2'b00, 2'b00);
            chk("t3_after_dip_sb", sb0, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'b00, 2'b00);
        chk("t3_released_sb", sb0, 1'b0);
        step(1'b0, 1'b0, 2'b00, GREEN);
        chk("t3_green_clear_sb", sb1, 1'b0);
        step(1'b0, 1'b0, 2'b00, 2'b00);

        // T4 latch: 6-cycle pulse on A, light red.
        for (int i = 0; i < 14; i++) begin
            step((i < 6), 1'b0, 2'b00, 2'b00);
            if (i == 4)  chk("t4_e4_sa_lat", sa1, 1'b0);
            if (i == 5)  chk("t4_e5_sa_lat", sa1, 1'b1);
            if (i == 13) chk("t4_hold_sa_lat", sa1, 1'b1);
            if (i == 13) chk("t4_level_gone", sa0, 1'b0);
        end
        step(1'b0, 1'b0, GREEN, 2'b00);
        chk("t4_green_clear", sa1, 1'b0);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        chk("t4_stays_clear", sa1, 1'b0);

        // T5: green on the very edge that enters PRESENT.
        for (int i = 0; i < 22; i++) begin
            step((i < 10), 1'b0, (i == 5) ? GREEN : 2'b00, 2'b00);
            if (i == 6)  chk("t5_present_sa_lat", sa1, 1'b1);
            if (i == 16) chk("t5_no_pend_sa_lat", sa1, 1'b0);
        end

        // T6 independence: random run lengths on both lines, random lights.
        begin
            logic ra, rb;
            int   run_a, run_b;
            ra = 1'b0; rb = 1'b0;
            run_a = 0; run_b = 0;
            for (int i = 0; i < 300; i++) begin
                if (run_a == 0) begin ra = ~ra; run_a = $urandom_range(1, 9); end
                if (run_b == 0) begin rb = ~rb; run_b = $urandom_range(1, 9); end
                run_a--;
                run_b--;
                step(ra, rb,
                     ($urandom_range(0, 7) == 0) ? GREEN : 2'($urandom_range(0, 3) & 1),
                     ($urandom_range(0, 7) == 0) ? GREEN : 2'($urandom_range(0, 3) | 1));
            end
        end

        // T1 async reset mid-PRESENT.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, GREEN, GREEN);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'b00, 2'b00);
        chk("t1_pre_sa_lvl", sa0, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk("t1_async_sa_lvl", sa0, 1'b0);
        chk("t1_async_sa_lat", sa1, 1'b0);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        raw_a = 1'b0;
        RST   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 2'b00, 2'b00);
            chk("t1_after_sa_lvl", sa0, 1'b0);
            chk("t1_after_sa_lat", sa1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
